// File: rtl/out_channel_if.sv
// Out-channel handshake bundle: the machine writes words on the wr_* side and
// the downstream sink drains them on the rd_* side.
interface out_channel_if #(
  parameter int W = 12
);
  logic         wr_valid;
  logic [W-1:0] wr_data;
  logic         wr_ready;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic         rd_ready;

  // Buffer side: accepts writes, presents the head word.
  modport slave (
    input  wr_valid, wr_data, rd_ready,
    output wr_ready, rd_valid, rd_data
  );

  // Environment side: produces writes, consumes the head word.
  modport master (
    output wr_valid, wr_data, rd_ready,
    input  wr_ready, rd_valid, rd_data
  );
endinterface

// File: rtl/out_channel_reader.sv
// Consumer end of the program out channel. Words are buffered in a circular
// buffer, streamed to the sink over valid/ready, and checked against an
// expected vector so a test harness can watch finished/success.
module out_channel_reader #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 3,
  parameter int NExpect            = 3,
  parameter int TimeoutSteps       = 10
) (
  input  logic                                  clock_i,
  input  logic                                  reset_i,    // active low, synchronous
  out_channel_if.slave                          ch,
  input  logic [NExpect*MemoryElementWidth-1:0] expected_i,
  output logic [15:0]                           popped_o,
  output logic                                  overflow_o,
  output logic                                  finished_o,
  output logic                                  success_o
);

  localparam int W  = MemoryElementWidth;
  localparam int PW = (NOut > 1) ? $clog2(NOut) : 1;
  localparam int OW = $clog2(NOut + 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NOut - 1);
  localparam logic [OW-1:0] OCC_FULL = OW'(NOut);

  typedef enum logic {ST_RUN, ST_DONE} state_t;

  logic [W-1:0]  mem_q [NOut];
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [OW-1:0] occ_q, occ_d;
  logic [W-1:0]  rd_data_q;
  logic [31:0]   steps_q, steps_d;
  logic [15:0]   popped_q, popped_d;
  logic          overflow_q, overflow_d;
  logic          mismatch_q, mismatch_d;
  logic          finished_q, success_q;
  state_t        state_q;

  logic          wr_ready, rd_valid, push, pop, bypass;
  logic          finish_cond, success_d;
  logic [W-1:0]  exp_words [NExpect];
  logic [W-1:0]  exp_word;

  // Pointers wrap at NOut-1, so any depth works, not just powers of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Unpack the flat expected vector into one word per slot.
  for (genvar gi = 0; gi < NExpect; gi++) begin : g_exp
    assign exp_words[gi] = expected_i[gi*W +: W];
  end

  // Handshake: everything is held off while reset is asserted.
  assign wr_ready    = reset_i && (occ_q < OCC_FULL);
  assign rd_valid    = reset_i && (occ_q != '0);
  assign push        = ch.wr_valid && wr_ready;
  assign pop         = rd_valid && ch.rd_ready;
  assign ch.wr_ready = wr_ready;
  assign ch.rd_valid = rd_valid;
  assign ch.rd_data  = rd_valid ? rd_data_q : '0;

  // Next-state for pointers, occupancy, counters and sticky flags.
  always_comb begin
    head_d = pop  ? ptr_inc(head_q) : head_q;
    tail_d = push ? ptr_inc(tail_q) : tail_q;
    occ_d  = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
    // The slot that becomes head is being written this edge only when the
    // buffer drains to empty before the push; then the head register must
    // take the incoming word instead of the stale RAM contents.
    bypass = push && (head_d == tail_q);

    exp_word = '0;
    for (int k = 0; k < NExpect; k++) begin
      if (popped_q == 16'(k)) exp_word = exp_words[k];
    end

    steps_d    = (steps_q == 32'hFFFF_FFFF) ? steps_q : steps_q + 32'd1;
    popped_d   = (pop && popped_q != 16'hFFFF) ? popped_q + 16'd1 : popped_q;
    overflow_d = overflow_q || (ch.wr_valid && !wr_ready);
    mismatch_d = mismatch_q ||
                 (pop && (({1'b0, popped_q} >= 17'(NExpect)) || (ch.rd_data != exp_word)));

    finish_cond = (({1'b0, steps_q} + 33'd1) > 33'(TimeoutSteps)) ||
                  (pop && (({1'b0, popped_q} + 17'd1) == 17'(NExpect)));
    success_d   = ({1'b0, popped_d} == 17'(NExpect)) && !mismatch_d && !overflow_d;
  end

  // Buffer RAM write port; contents intentionally survive reset.
  always_ff @(posedge clock_i) begin
    if (push) mem_q[tail_q] <= ch.wr_data;
  end

  // Buffer bookkeeping and registered head-word read.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      occ_q      <= '0;
      rd_data_q  <= '0;
      steps_q    <= '0;
      popped_q   <= '0;
      overflow_q <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      occ_q      <= occ_d;
      rd_data_q  <= (occ_d == '0) ? '0 : (bypass ? ch.wr_data : mem_q[head_d]);
      steps_q    <= steps_d;
      popped_q   <= popped_d;
      overflow_q <= overflow_d;
      mismatch_q <= mismatch_d;
    end
  end

  // Checker FSM: RUN until the finish condition, then DONE with frozen result.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q    <= ST_RUN;
      finished_q <= 1'b0;
      success_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (finish_cond) begin
            state_q    <= ST_DONE;
            finished_q <= 1'b1;
            success_q  <= success_d;
          end
        end
        default: state_q <= ST_DONE;
      endcase
    end
  end

  assign popped_o   = popped_q;
  assign overflow_o = overflow_q;
  assign finished_o = finished_q;
  assign success_o  = success_q;

endmodule

// File: tb/tb_out_channel_reader.sv
// Directed bench for out_channel_reader: instance A uses the default
// parameters, instance B has a 6-word expected vector for the wrap test.
module tb_out_channel_reader;

  localparam int W = 12;

  logic clk = 1'b0;
  logic ra, rb;
  logic [3*W-1:0] exa;
  logic [6*W-1:0] exb;
  logic [15:0] popa, popb;
  logic ova, ovb, fina, finb, suca, sucb;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  out_channel_if #(.W(W)) ifa ();
  out_channel_if #(.W(W)) ifb ();

  out_channel_reader #(
    .MemoryElementWidth(W), .NOut(3), .NExpect(3), .TimeoutSteps(10)
  ) dut_a (
    .clock_i(clk), .reset_i(ra), .ch(ifa), .expected_i(exa),
    .popped_o(popa), .overflow_o(ova), .finished_o(fina), .success_o(suca)
  );

  out_channel_reader #(
    .MemoryElementWidth(W), .NOut(3), .NExpect(6), .TimeoutSteps(40)
  ) dut_b (
    .clock_i(clk), .reset_i(rb), .ch(ifb), .expected_i(exb),
    .popped_o(popb), .overflow_o(ovb), .finished_o(finb), .success_o(sucb)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_a();
    ra = 1'b0;
    ifa.wr_valid = 1'b0;
    ifa.wr_data  = '0;
    ifa.rd_ready = 1'b0;
    tick();
    ra = 1'b1;
    #1;
  endtask

  // Push three words back to back with the sink always ready.
  task automatic push3(input string t, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] c, input logic exp_succ);
    ifa.rd_ready = 1'b1;
    ifa.wr_valid = 1'b1;
    ifa.wr_data  = a;
    tick();
    chk({t, " rd_valid after push 1"}, 32'(ifa.rd_valid), 32'd1);
    chk({t, " rd_data after push 1"}, 32'(ifa.rd_data), 32'(a));
    ifa.wr_data = b;
    tick();
    chk({t, " rd_data after push 2"}, 32'(ifa.rd_data), 32'(b));
    chk({t, " popped after pop 1"}, 32'(popa), 32'd1);
    ifa.wr_data = c;
    tick();
    chk({t, " rd_data after push 3"}, 32'(ifa.rd_data), 32'(c));
    chk({t, " finished before last pop"}, 32'(fina), 32'd0);
    ifa.wr_valid = 1'b0;
    tick();
    chk({t, " finished"}, 32'(fina), 32'd1);
    chk({t, " success"}, 32'(suca), 32'(exp_succ));
    chk({t, " popped"}, 32'(popa), 32'd3);
    chk({t, " rd_valid empty"}, 32'(ifa.rd_valid), 32'd0);
  endtask

  initial begin
    ra = 1'b0;
    rb = 1'b0;
    exa = {12'd33, 12'd22, 12'd11};
    exb = {12'd6, 12'd5, 12'd4, 12'd3, 12'd2, 12'd1};
    ifb.wr_valid = 1'b0;
    ifb.wr_data  = '0;
    ifb.rd_ready = 1'b0;

    // Reset state
    reset_a();
    chk("reset popped", 32'(popa), 32'd0);
    chk("reset overflow", 32'(ova), 32'd0);
    chk("reset finished", 32'(fina), 32'd0);
    chk("reset rd_valid", 32'(ifa.rd_valid), 32'd0);
    chk("reset wr_ready", 32'(ifa.wr_ready), 32'd1);

    // Test 1: clean stream
    push3("t1", 12'd11, 12'd22, 12'd33, 1'b1);

    // Test 2: overflow with sink stalled
    reset_a();
    ifa.rd_ready = 1'b0;
    ifa.wr_valid = 1'b1;
    ifa.wr_data = 12'd11; tick();
    ifa.wr_data = 12'd22; tick();
    ifa.wr_data = 12'd33; tick();
    chk("t2 wr_ready when full", 32'(ifa.wr_ready), 32'd0);
    chk("t2 overflow before 4th", 32'(ova), 32'd0);
    ifa.wr_data = 12'd44; tick();
    chk("t2 overflow set", 32'(ova), 32'd1);
    ifa.wr_valid = 1'b0;
    ifa.rd_ready = 1'b1;
    chk("t2 drain 1", 32'(ifa.rd_data), 32'd11);
    tick();
    chk("t2 drain 2", 32'(ifa.rd_data), 32'd22);
    tick();
    chk("t2 drain 3", 32'(ifa.rd_data), 32'd33);
    tick();
    chk("t2 finished", 32'(fina), 32'd1);
    chk("t2 success", 32'(suca), 32'd0);
    chk("t2 empty after 3", 32'(ifa.rd_valid), 32'd0);

    // Test 3: wrong middle word
    reset_a();
    push3("t3", 12'd11, 12'd99, 12'd33, 1'b0);

    // Test 4: timeout with only two words
    reset_a();
    ifa.rd_ready = 1'b1;
    ifa.wr_valid = 1'b1;
    ifa.wr_data = 12'd11; tick();
    ifa.wr_data = 12'd22; tick();
    ifa.wr_valid = 1'b0;
    for (int e = 3; e <= 10; e++) tick();
    chk("t4 finished at edge 10", 32'(fina), 32'd0);
    chk("t4 popped", 32'(popa), 32'd2);
    tick();
    chk("t4 finished at edge 11", 32'(fina), 32'd1);
    chk("t4 success", 32'(suca), 32'd0);

    // Test 6: reset mid-operation, then a clean rerun
    reset_a();
    ifa.rd_ready = 1'b0;
    ifa.wr_valid = 1'b1;
    ifa.wr_data = 12'd11; tick();
    ifa.wr_data = 12'd22; tick();
    ifa.wr_valid = 1'b0;
    ra = 1'b0;
    #1;
    chk("t6 rd_valid in reset", 32'(ifa.rd_valid), 32'd0);
    chk("t6 rd_data in reset", 32'(ifa.rd_data), 32'd0);
    chk("t6 wr_ready in reset", 32'(ifa.wr_ready), 32'd0);
    tick();
    ra = 1'b1;
    #1;
    chk("t6 rd_valid after reset", 32'(ifa.rd_valid), 32'd0);
    chk("t6 popped after reset", 32'(popa), 32'd0);
    chk("t6 overflow after reset", 32'(ova), 32'd0);
    chk("t6 finished after reset", 32'(fina), 32'd0);
    push3("t6 rerun", 12'd11, 12'd22, 12'd33, 1'b1);

    // Test 5: bursty pushes, toggling sink, two pointer wraps
    begin
      int next_push = 1;
      int next_pop  = 1;
      int cyc       = 0;
      rb = 1'b0;
      tick();
      rb = 1'b1;
      #1;
      while (next_pop <= 6 && cyc < 60) begin
        ifb.rd_ready = (cyc % 2 == 0);
        ifb.wr_valid = ((cyc % 5) < 3) && (next_push <= 6) && ifb.wr_ready;
        ifb.wr_data  = 12'(next_push);
        #1;
        if (ifb.rd_valid && ifb.rd_ready) begin
          chk($sformatf("t5 pop %0d", next_pop), 32'(ifb.rd_data), 32'(next_pop));
          next_pop++;
        end
        if (ifb.wr_valid) next_push++;
        tick();
        cyc++;
      end
      ifb.wr_valid = 1'b0;
      ifb.rd_ready = 1'b0;
      chk("t5 all popped in budget", 32'(next_pop), 32'd7);
      chk("t5 finished", 32'(finb), 32'd1);
      chk("t5 success", 32'(sucb), 32'd1);
      chk("t5 popped", 32'(popb), 32'd6);
      chk("t5 overflow", 32'(ovb), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
